dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 35 +++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

  // Lanes off..off+size-1, clipped to the word; beat 2 reuses it with off=0.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i] = (i >= int'(off)) && (i < int'(off) + int'(size));
    end
    return m;
  endfunction

  function automatic logic size_ok(input logic [2:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
  endfunction

  function automatic logic is_split(input logic [1:0] off, input logic [2:0] size);
    return ({2'b00, off} + {1'b0, size}) > 4'd4;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Per-beat byte-lane mask, write-data lane placement and right-justified read extraction.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic        beat2_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  tail_sz;
  logic [5:0]  head_sh;
  logic [5:0]  tail_sh;
  logic [31:0] bmask;

  // Beat 2 carries the bytes that spilled past lane 3; beat 1 already took 4-off of them.
  assign tail_sz = {1'b0, off_i} + size_i - 3'd4;
  assign head_sh = {1'b0, off_i, 3'b000};
  assign tail_sh = 6'd32 - head_sh;

  always_comb begin
    bmask  = '0;
    mask_o = beat2_i ? lane_mask(2'd0, tail_sz) : lane_mask(off_i, size_i);
    for (int b = 0; b < 4; b++) begin
      bmask[8*b +: 8] = {8{mask_o[b]}};
    end
    wlanes_o = beat2_i ? (wdata_i >> tail_sh) : (wdata_i << head_sh);
    rdata_o  = beat2_i ? ((rword_i & bmask) << tail_sh) : ((rword_i & bmask) >> head_sh);
  end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed load/store responder over a word array; word-crossing accesses take two
// beats (busy_o high for the second), reads return registered, right-justified data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [31:0] rd_addr_i,
  input  logic [2:0]  rd_size_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  input  logic        wd_en,
  input  logic [31:0] wd_addr_i,
  input  logic [2:0]  wd_size_i,
  input  logic [31:0] wd_data_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  reg [31:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic            rd_pend_q, rd_pend_d, wd_pend_q, wd_pend_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d, wd_idx_q, wd_idx_d;
  logic [1:0]      rd_off_q, rd_off_d, wd_off_q, wd_off_d;
  logic [2:0]      rd_size_q, rd_size_d, wd_size_q, wd_size_d;
  logic [31:0]     wd_data_q, wd_data_d;
  logic [31:0]     rd_hold_q, rd_hold_d, rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d, err_q, err_d;

  logic            in_split, rd_acc, wd_acc, rd_ok, wd_ok, rd_spl, wd_spl, w_we;
  logic [1:0]      r_off, w_off;
  logic [2:0]      r_size, w_size;
  logic [AW-1:0]   r_idx, w_idx;
  logic [31:0]     r_word, r_data, w_data, w_lanes;
  logic [3:0]      w_mask;
  logic [3:0]      unused_r_mask;
  logic [31:0]     unused_r_wlanes, unused_w_rdata;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^{rd_addr_i[31:2+AW], wd_addr_i[31:2+AW]};

  assign in_split = (state_q == ST_SPLIT);
  assign rd_acc   = rd_en && !in_split;
  assign wd_acc   = wd_en && !in_split;
  assign rd_ok    = rd_acc && size_ok(rd_size_i);
  assign wd_ok    = wd_acc && size_ok(wd_size_i);
  assign rd_spl   = rd_ok && is_split(rd_addr_i[1:0], rd_size_i);
  assign wd_spl   = wd_ok && is_split(wd_addr_i[1:0], wd_size_i);

  // During SPLIT both paths run from the latched fields against word N+1.
  assign r_off  = in_split ? rd_off_q  : rd_addr_i[1:0];
  assign r_size = in_split ? rd_size_q : rd_size_i;
  assign r_idx  = in_split ? rd_idx_q  : rd_addr_i[2 +: AW];
  assign w_off  = in_split ? wd_off_q  : wd_addr_i[1:0];
  assign w_size = in_split ? wd_size_q : wd_size_i;
  assign w_idx  = in_split ? wd_idx_q  : wd_addr_i[2 +: AW];
  assign w_data = in_split ? wd_data_q : wd_data_i;
  assign w_we   = in_split ? wd_pend_q : wd_ok;
  assign r_word = mem[r_idx];

  dmem_lane_align u_rd_align (
    .off_i(r_off), .size_i(r_size), .beat2_i(in_split), .wdata_i(32'd0), .rword_i(r_word),
    .mask_o(unused_r_mask), .wlanes_o(unused_r_wlanes), .rdata_o(r_data)
  );

  dmem_lane_align u_wd_align (
    .off_i(w_off), .size_i(w_size), .beat2_i(in_split), .wdata_i(w_data), .rword_i(32'd0),
    .mask_o(w_mask), .wlanes_o(w_lanes), .rdata_o(unused_w_rdata)
  );

  always_comb begin
    state_d    = state_q;
    rd_pend_d  = rd_pend_q;
    wd_pend_d  = wd_pend_q;
    rd_idx_d   = rd_idx_q;
    wd_idx_d   = wd_idx_q;
    rd_off_d   = rd_off_q;
    wd_off_d   = wd_off_q;
    rd_size_d  = rd_size_q;
    wd_size_d  = wd_size_q;
    wd_data_d  = wd_data_q;
    rd_hold_d  = rd_hold_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = (rd_acc && !size_ok(rd_size_i)) || (wd_acc && !size_ok(wd_size_i));
    case (state_q)
      ST_IDLE: begin
        if (rd_spl || wd_spl) begin
          state_d   = ST_SPLIT;
          rd_pend_d = rd_spl;
          wd_pend_d = wd_spl;
          rd_idx_d  = rd_addr_i[2 +: AW] + AW'(1);
          wd_idx_d  = wd_addr_i[2 +: AW] + AW'(1);
          rd_off_d  = rd_addr_i[1:0];
          wd_off_d  = wd_addr_i[1:0];
          rd_size_d = rd_size_i;
          wd_size_d = wd_size_i;
          wd_data_d = wd_data_i;
        end
        if (rd_spl) begin
          rd_hold_d = r_data;
        end else if (rd_ok) begin
          rd_valid_d = 1'b1;
          rd_data_d  = r_data;
        end
      end
      ST_SPLIT: begin
        state_d = ST_IDLE;
        if (rd_pend_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_hold_q | r_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= 1'b0;
      wd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      wd_idx_q   <= '0;
      rd_off_q   <= '0;
      wd_off_q   <= '0;
      rd_size_q  <= '0;
      wd_size_q  <= '0;
      wd_data_q  <= '0;
      rd_hold_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      wd_pend_q  <= wd_pend_d;
      rd_idx_q   <= rd_idx_d;
      wd_idx_q   <= wd_idx_d;
      rd_off_q   <= rd_off_d;
      wd_off_q   <= wd_off_d;
      rd_size_q  <= rd_size_d;
      wd_size_q  <= wd_size_d;
      wd_data_q  <= wd_data_d;
      rd_hold_q  <= rd_hold_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = in_split;
  assign err_o      = err_q;

endmodule
